// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the fetch/data memory access sequencer.
// State encodings, NOP word and full-word byte-enable mask.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [3:0]  BE_WORD  = 4'b1111;

  function automatic logic is_req(input state_e s);
    return (s == S_FETCH) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout.sv
// Bus request watchdog: counts un-acked request cycles and flags
// the cycle in which the request must be abandoned.
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final cycle takes priority over expiry.
  assign expired_o = en_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one memory port between instruction fetch and data
// access; holds the fetched word and strobes commit per instruction.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        commit,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        in_req;
  logic        expired;

  assign in_req = is_req(state_q);

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (~in_req),
    .en_i     (in_req),
    .ack_i    (bus_ack),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    ivalid_d  = ivalid_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        bus_req  = 1'b1;
        bus_addr = fetch_addr;
        bus_be   = BE_WORD;
        if (bus_ack) begin
          instr_d  = bus_rdata;
          ivalid_d = 1'b1;
          state_d  = S_EXEC;
        end else if (expired) begin
          instr_d = NOP_INSTR;
          err_d   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = d_req ? S_DATA : S_COMMIT;
      end
      S_DATA: begin
        bus_req   = 1'b1;
        bus_we    = d_we;
        bus_addr  = d_addr;
        bus_wdata = d_wdata;
        bus_be    = d_we ? d_be : BE_WORD;
        if (bus_ack) begin
          if (!d_we) rdata_d = bus_rdata;
          state_d = S_COMMIT;
        end else if (expired) begin
          // Abandoned loads return zero; abandoned stores vanish.
          if (!d_we) rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        ivalid_d = 1'b0;
        state_d  = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= NOP_INSTR;
      ivalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = ivalid_q;
  assign d_rdata     = rdata_q;
  assign bus_err     = err_q;
  assign commit      = (state_q == S_COMMIT) && !reset;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of instruction
// scenarios plus hand-written reset corner sequences.
module tb_mem_access_ctrl;

  localparam int NEVER = 99;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        commit;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(4),
    .NOP_INSTR     (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_rdata    (d_rdata),
    .commit     (commit),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fa;
    logic [31:0] iw;
    int          fw;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    int          dw;
    logic [31:0] drd;
    int          ecommit;
    logic [31:0] einstr;
    logic [31:0] erd;
    int          eerr;
    logic        eiv;
    logic [3:0]  ebe;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; the bus model acks after w wait states.
  task automatic run_vec(input vec_t v, input int idx,
                         output int waited);
    int          seg;
    int          k;
    int          w;
    int          commit_at;
    int          nerr;
    logic        prev_req;
    logic        unstable;
    logic        fa_bad;
    logic [68:0] cap;
    fetch_addr = v.fa;
    d_req      = v.dreq;
    d_we       = v.dwe;
    d_addr     = v.daddr;
    d_wdata    = v.dwd;
    d_be       = v.dbe;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    waited     = 0;
    while (!bus_req && waited < 20) begin
      step();
      waited++;
    end
    seg = 0; k = 0; commit_at = -1; nerr = 0;
    prev_req = 1'b0; unstable = 1'b0; fa_bad = 1'b0;
    cap = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus_req) begin
        if (!prev_req) begin
          seg++;
          k = 0;
          if (seg == 2) begin
            cap = {bus_we, bus_addr, bus_wdata, bus_be};
            chk($sformatf("v%0d data addr", idx), bus_addr, v.daddr);
            chk($sformatf("v%0d data we", idx), 32'(bus_we), 32'(v.dwe));
            chk($sformatf("v%0d data be", idx), 32'(bus_be), 32'(v.ebe));
            chk($sformatf("v%0d data wdata", idx), bus_wdata, v.dwd);
          end
        end
        if (seg == 1 && (bus_addr !== v.fa || bus_we !== 1'b0
            || bus_be !== 4'hF))
          fa_bad = 1'b1;
        if (seg == 2 && {bus_we, bus_addr, bus_wdata, bus_be} !== cap)
          unstable = 1'b1;
        w = (seg == 1) ? v.fw : v.dw;
        bus_ack = (k == w);
        if (k == w)
          bus_rdata = (seg == 1) ? v.iw : v.drd;
        else
          bus_rdata = 32'hBAD0_BAD0;
        k++;
      end else begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
      end
      prev_req = bus_req;
      if (bus_err) nerr++;
      if (commit) begin
        commit_at = cyc;
        break;
      end
      step();
    end
    bus_ack = 1'b0;
    if (commit_at < 0) begin
      errors++;
      $display("FAIL v%0d commit: got none expected cycle %0d",
               idx, v.ecommit);
    end
    chk($sformatf("v%0d commit cycle", idx), commit_at, v.ecommit);
    chk($sformatf("v%0d instr", idx), instr, v.einstr);
    chk($sformatf("v%0d instr_valid", idx), 32'(instr_valid), 32'(v.eiv));
    chk($sformatf("v%0d d_rdata", idx), d_rdata, v.erd);
    chk($sformatf("v%0d bus_err count", idx), nerr, v.eerr);
    chk($sformatf("v%0d fetch fields", idx), 32'(fa_bad), 0);
    chk($sformatf("v%0d data stable", idx), 32'(unstable), 0);
    chk($sformatf("v%0d data reqs", idx), seg, v.dreq ? 2 : 1);
  endtask

  initial begin
    int waited;
    tbl[0] = '{32'h00, 32'h0050_0093, 0, 0, 0, 32'h0, 32'h0, 4'h0,
               0, 32'h0, 2, 32'h0050_0093, 32'h0, 0, 1, 4'h0};
    tbl[1] = '{32'h04, 32'h0000_2083, 0, 1, 0, 32'h100, 32'h0, 4'h0,
               2, 32'hDEAD_BEEF, 5, 32'h0000_2083, 32'hDEAD_BEEF,
               0, 1, 4'hF};
    tbl[2] = '{32'h08, 32'h0011_2223, 1, 1, 1, 32'h204, 32'h1234_5678,
               4'b0011, 1, 32'hFFFF_FFFF, 5, 32'h0011_2223,
               32'hDEAD_BEEF, 0, 1, 4'b0011};
    tbl[3] = '{32'h0C, 32'hFFFF_FFFF, NEVER, 0, 0, 32'h0, 32'h0, 4'h0,
               0, 32'h0, 5, 32'h0000_0013, 32'hDEAD_BEEF, 1, 0, 4'h0};
    tbl[4] = '{32'h10, 32'h00A0_0113, 3, 0, 0, 32'h0, 32'h0, 4'h0,
               0, 32'h0, 5, 32'h00A0_0113, 32'hDEAD_BEEF, 0, 1, 4'h0};
    tbl[5] = '{32'h14, 32'h0000_2183, 0, 1, 0, 32'h300, 32'h0, 4'h0,
               NEVER, 32'h0, 6, 32'h0000_2183, 32'h0, 1, 1, 4'hF};
    tbl[6] = '{32'h18, 32'h0000_2203, 0, 1, 0, 32'h304, 32'h0, 4'h0,
               3, 32'hCAFE_F00D, 6, 32'h0000_2203, 32'hCAFE_F00D,
               0, 1, 4'hF};
    tbl[7] = '{32'h1C, 32'h0041_2423, 0, 1, 1, 32'h308, 32'hA5A5_5A5A,
               4'b1100, NEVER, 32'h0, 6, 32'h0041_2423, 32'hCAFE_F00D,
               1, 1, 4'b1100};

    reset = 1'b1; fetch_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) step();
    chk("reset instr", instr, 32'h0000_0013);
    chk("reset d_rdata", d_rdata, 32'h0);
    chk("reset instr_valid", 32'(instr_valid), 0);
    chk("reset bus_req", 32'(bus_req), 0);
    chk("reset commit", 32'(commit), 0);
    chk("reset bus_err", 32'(bus_err), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], i, waited);
      if (i == 0) chk("first req cycle", waited, 1);
    end

    // Reset while a load is on the bus, late ack arriving after it.
    fetch_addr = 32'h20; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h400; d_be = 4'h0;
    step();
    chk("rst seq fetch req", 32'(bus_req), 1);
    bus_ack = 1'b1; bus_rdata = 32'h0000_2103;
    step();
    bus_ack = 1'b0;
    step();
    chk("rst seq data req", 32'(bus_req), 1);
    chk("rst seq data addr", bus_addr, 32'h400);
    reset = 1'b1; fetch_addr = 32'h40;
    step();
    chk("rst seq req dropped", 32'(bus_req), 0);
    chk("rst seq no commit", 32'(commit), 0);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
    step();
    bus_ack = 1'b0;
    chk("rst seq d_rdata", d_rdata, 32'h0);
    chk("rst seq instr", instr, 32'h0000_0013);
    chk("rst seq instr_valid", 32'(instr_valid), 0);
    chk("rst seq refetch req", 32'(bus_req), 1);
    chk("rst seq refetch addr", bus_addr, 32'h40);
    d_req = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h0030_0193;
    step();
    bus_ack = 1'b0;
    chk("refetch instr", instr, 32'h0030_0193);
    chk("refetch instr_valid", 32'(instr_valid), 1);
    chk("refetch req low", 32'(bus_req), 0);
    step();
    chk("commit strobe", 32'(commit), 1);
    reset = 1'b1;
    #1;
    chk("commit gated by reset", 32'(commit), 0);
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Multi-cycle sequencer that shares one external memory port between instruction fetch and data load/store for the RV32 datapath.
- Fetches the instruction at the current PC and holds it stable while the datapath evaluates.
- Runs a data access when the instruction needs one.
- Issues a one-cycle commit strobe that advances the PC and enables the register-file write.
- Sits between the datapath/decoder (core side) and the RAM/ROM bus (bus side).

Parameters:
TIMEOUT_CYCLES, 255, bus cycles without bus_ack before a request is abandonedm; legal range 1..65535.
NOP_INSTR, 32'h00000013, instruction substituted on reset and on fetch timeout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
fetch_addr  in  32  current PC from datapath pc_out
instr  out  32  latched instruction to decoder/datapath
instr_valid  out  1  instr holds a fetched word for the current instruction
d_req  in  1  current instruction needs a data access (decoder)
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address (alu_res)
d_wdata  in  32  store data (write_data)
d_be  in  4  byte enables for the store
d_rdata  out  32  latched load data to load_module
commit  out  1  one-cycle strobe: PC register enable and reg_file_we3 gate
bus_err  out  1  one-cycle pulse when a request times out
bus_req  out  1  bus request, held until bus_ack or timeout
bus_we  out  1  bus write
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_be  out  4  bus byte enables
bus_ack  in  1  bus completion; read data valid in the same cycle
bus_rdata  in  32  bus read data

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high: sampled on the rising edge of clk; while high, the state is forced to S_IDLE.
- States: S_IDLE, S_FETCH, S_EXEC, S_DATA, S_COMMIT.
- Reset values:
  - instr = NOP_INSTR, d_rdata = 0.
  - instr_valid = 0, commit = 0, bus_err = 0, bus_req = 0.
  - Timeout counter = 0.
- S_IDLE: bus_req = 0. Always goes to S_FETCH on the next cycle.
- S_FETCH:
  - Drives bus_req = 1, bus_we = 0, bus_addr = fetch_addr, bus_be = 4'b1111, bus_wdata = 0.
  - On bus_ack: instr <= bus_rdata, instr_valid <= 1, go to S_EXEC.
- S_EXEC: one settle cycle with bus_req = 0. If d_req, go to S_DATA; else go to S_COMMIT.
- S_DATA:
  - Drives bus_req = 1, bus_we = d_we, bus_addr = d_addr, bus_wdata = d_wdata.
  - bus_be = d_be for stores, 4'b1111 for loads.
  - On bus_ack: if a load, d_rdata <= bus_rdata; a store leaves d_rdata unchanged. Go to S_COMMIT.
- S_COMMIT: commit = 1 for exactly this cycle, then go to S_FETCH. instr_valid clears on entry to S_FETCH.
- Bus outputs are a combinational decode of state and the stable inputs. Core inputs are stable while instr is held, so bus signals stay constant while bus_req is high.
- Latency with a zero-wait bus (ack in the first request cycle):
  - Non-memory instruction: 3 cycles per instruction.
  - Load/store: 4 cycles per instruction.
  - Each wait state adds 1 cycle.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to S_FETCH or S_DATA.
  - Increments each request cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES with no ack, the request is abandoned: bus_err pulses for 1 cycle.
  - Fetch timeout: instr <= NOP_INSTR, go to S_EXEC.
  - Data timeout: load gives d_rdata <= 0; store is dropped. Go to S_COMMIT.
- Boundary cases:
  - bus_ack in the same cycle as the timeout: ack wins, no bus_err.
  - bus_ack while bus_req = 0 (S_IDLE, S_EXEC, S_COMMIT): ignored.
  - d_req sampled only in S_EXEC.
  - Reset mid-request: bus_req drops on the cycle after reset is sampled. A late ack is ignored, and the next fetch restarts from fetch_addr.
  - commit is never asserted in any cycle with reset high.

Decomposition:
- Shared header mem_ctrl_defs.vh:
  - State encodings S_IDLE..S_COMMIT (3-bit).
  - NOP constant 32'h00000013.
  - BE_WORD = 4'b1111.
- One sub-module, bus_timeout_cnt: clear/enable/ack inputs, expired output, parameterised by TIMEOUT_CYCLES.
- FSM and output decode stay in mem_access_ctrl.

Test Plan:
- Reset high 3 cycles, then low; fetch_addr = 0, ack immediately with 0x00500093 → bus_req in cycle 1 after reset, instr = 0x00500093, commit pulses 3 cycles after fetch start; no bus_err.
- Load: d_req = 1, d_we = 0, d_addr = 0x100; ack after 2 wait states with 0xDEADBEEF → bus_addr = 0x100, bus_be = 4'b1111, d_rdata = 0xDEADBEEF, commit 6 cycles after fetch start.
- Store: d_we = 1, d_addr = 0x204, d_wdata = 0x12345678, d_be = 4'b0011 → bus_we = 1 and all bus fields stable until ack; d_rdata unchanged; single commit.
- Fetch timeout with TIMEOUT_CYCLES = 4 and no ack → bus_err single pulse after 4 request cycles, instr = 0x00000013, commit follows.
- Ack coincident with the timeout cycle → bus_err = 0, data latched.
- Reset asserted during S_DATA with ack 1 cycle later → no commit, no d_rdata update, bus_req low, restart fetch at the current fetch_addr.
